// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external adder among NREQ requesters.
// A lock bit chains consecutive grants into a multi-word add through the registered carry.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_lock,
    input  logic [NREQ*WIDTH-1:0] i_a_in,
    input  logic [NREQ*WIDTH-1:0] i_b_in,
    input  logic [NREQ-1:0]       i_cin_in,
    output logic [NREQ-1:0]       o_gnt,
    output logic [WIDTH-1:0]      o_add_a,
    output logic [WIDTH-1:0]      o_add_b,
    output logic                  o_add_cin,
    input  logic [WIDTH-1:0]      i_add_out,
    input  logic                  i_add_cout,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [IDW-1:0]        o_res_id,
    output logic [WIDTH-1:0]      o_res_sum,
    output logic                  o_res_cout,
    output logic                  o_locked
);

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_owner;
    logic             r_carry;
    logic             r_resValid;
    logic [IDW-1:0]   r_resId;
    logic [WIDTH-1:0] r_resSum;
    logic             r_resCout;

    logic             w_free;
    logic             w_hasWinner;
    logic [IDW-1:0]   w_winner;
    logic [IDW-1:0]   w_cand;
    logic             w_grant;
    logic [WIDTH-1:0] w_aArr [NREQ];
    logic [WIDTH-1:0] w_bArr [NREQ];

    // Wrapping increment, also correct when NREQ is not a power of two.
    function automatic logic [IDW-1:0] incIdx(input logic [IDW-1:0] x);
        return (x == IDW'(NREQ - 1)) ? '0 : x + IDW'(1);
    endfunction

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_aArr[k] = i_a_in[k*WIDTH +: WIDTH];
            w_bArr[k] = i_b_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_free = !r_resValid || i_res_ready;

    // While locked only the owner may win; otherwise search upward from r_ptr.
    always_comb begin
        w_hasWinner = 1'b0;
        w_winner    = '0;
        w_cand      = r_ptr;
        if (r_state == ST_LOCKED) begin
            w_hasWinner = i_req[r_owner];
            w_winner    = r_owner;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!w_hasWinner && i_req[w_cand]) begin
                    w_hasWinner = 1'b1;
                    w_winner    = w_cand;
                end
                w_cand = incIdx(w_cand);
            end
        end
    end

    assign w_grant = !i_reset && w_free && w_hasWinner;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_ARB: begin
                if (w_grant && i_lock[w_winner]) begin
                    w_stateNext = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_grant && !i_lock[r_owner]) begin
                    w_stateNext = ST_ARB;
                end else if (w_free && !i_req[r_owner]) begin
                    w_stateNext = ST_ARB;
                end
            end
            default: w_stateNext = ST_ARB;
        endcase
    end

    always_comb begin
        o_gnt     = '0;
        o_add_a   = '0;
        o_add_b   = '0;
        o_add_cin = 1'b0;
        if (w_grant) begin
            o_gnt[w_winner] = 1'b1;
            o_add_a         = w_aArr[w_winner];
            o_add_b         = w_bArr[w_winner];
            o_add_cin       = (r_state == ST_LOCKED) ? r_carry : i_cin_in[w_winner];
        end
    end

    // Result slot, carry feedback and round-robin pointer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_resValid <= 1'b0;
            r_resId    <= '0;
            r_resSum   <= '0;
            r_resCout  <= 1'b0;
            r_carry    <= 1'b0;
            r_ptr      <= '0;
            r_owner    <= '0;
        end else begin
            if (w_grant) begin
                r_resValid <= 1'b1;
                r_resId    <= w_winner;
                r_resSum   <= i_add_out;
                r_resCout  <= i_add_cout;
                r_carry    <= i_add_cout;
            end else if (i_res_ready) begin
                r_resValid <= 1'b0;
            end
            if (r_state == ST_ARB && w_grant) begin
                r_ptr <= incIdx(w_winner);
                if (i_lock[w_winner]) begin
                    r_owner <= w_winner;
                end
            end else if (r_state == ST_LOCKED && w_stateNext == ST_ARB) begin
                r_ptr <= incIdx(r_owner);
            end
        end
    end

    assign o_res_valid = r_resValid;
    assign o_res_id    = r_resId;
    assign o_res_sum   = r_resSum;
    assign o_res_cout  = r_resCout;
    assign o_locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic against a rule-level model.
// The shared adder is modelled here as plain arithmetic on the DUT's adder outputs.
module tb_adder_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, lock, cinIn;
    logic [N*W-1:0] aIn, bIn;
    logic           resReady;
    logic [N-1:0]   gnt;
    logic [W-1:0]   addA, addB, addOut;
    logic           addCin, addCout;
    logic           resValid;
    logic [IW-1:0]  resId;
    logic [W-1:0]   resSum;
    logic           resCout;
    logic           locked;

    int nChecks = 0;
    int nFails  = 0;

    // Model state and this cycle's expectations.
    bit           mLocked, mCarry, mValid, mCout;
    int           mOwner, mPtr, mId;
    logic [W-1:0] mSum;
    int           eIdx;
    logic [N-1:0] eGnt;
    logic [W-1:0] eA, eB;
    logic         eCin;
    logic [W:0]   eTotal;

    adder_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_lock(lock),
        .i_a_in(aIn), .i_b_in(bIn), .i_cin_in(cinIn),
        .o_gnt(gnt), .o_add_a(addA), .o_add_b(addB), .o_add_cin(addCin),
        .i_add_out(addOut), .i_add_cout(addCout),
        .o_res_valid(resValid), .i_res_ready(resReady), .o_res_id(resId),
        .o_res_sum(resSum), .o_res_cout(resCout), .o_locked(locked)
    );

    always #5 clk = ~clk;

    assign {addCout, addOut} = {1'b0, addA} + {1'b0, addB} + {{W{1'b0}}, addCin};

    task automatic setOps(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        aIn[k*W +: W] = a;
        bIn[k*W +: W] = b;
        cinIn[k]      = c;
    endtask

    task automatic modelComb();
        bit free;
        free = !mValid || resReady;
        eIdx = -1;
        if (!reset && free) begin
            if (mLocked) begin
                if (req[mOwner]) eIdx = mOwner;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (eIdx < 0 && req[(mPtr + i) % N]) eIdx = (mPtr + i) % N;
                end
            end
        end
        eGnt = '0;
        eA   = '0;
        eB   = '0;
        eCin = 1'b0;
        if (eIdx >= 0) begin
            eGnt[eIdx] = 1'b1;
            eA   = aIn[eIdx*W +: W];
            eB   = bIn[eIdx*W +: W];
            eCin = mLocked ? mCarry : cinIn[eIdx];
        end
        eTotal = {1'b0, eA} + {1'b0, eB} + {{W{1'b0}}, eCin};
    endtask

    task automatic modelCommit();
        if (reset) begin
            mValid = 0; mSum = '0; mCout = 0; mId = 0;
            mLocked = 0; mPtr = 0; mCarry = 0; mOwner = 0;
        end else if (eIdx >= 0) begin
            mValid = 1;
            mSum   = eTotal[W-1:0];
            mCout  = eTotal[W];
            mCarry = eTotal[W];
            mId    = eIdx;
            if (mLocked) begin
                if (!lock[mOwner]) begin
                    mLocked = 0;
                    mPtr    = (mOwner + 1) % N;
                end
            end else begin
                mPtr = (eIdx + 1) % N;
                if (lock[eIdx]) begin
                    mLocked = 1;
                    mOwner  = eIdx;
                end
            end
        end else begin
            if (mLocked && (!mValid || resReady) && !req[mOwner]) begin
                mLocked = 0;
                mPtr    = (mOwner + 1) % N;
            end
            if (resReady) mValid = 0;
        end
    endtask

    task automatic settle();
        #1;
        modelComb();
    endtask

    task automatic clockEdge();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic doReset();
        reset = 1; req = '0; lock = '0; cinIn = '0; aIn = '0; bIn = '0; resReady = 1;
        settle();
        clockEdge();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; req = 4'($urandom); lock = '0; cinIn = '0; aIn = '0; bIn = '0; resReady = 1;
        settle();
        nChecks++;
        if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
        clockEdge();
        nChecks++;
        if ({resValid, locked} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_valid_locked got %b want 00", {resValid, locked}); end
        nChecks++;
        if ({resId, resSum, resCout} !== '0) begin nFails++; $display("[TB] FAIL reset_result got id=%0d sum=%h cout=%b want zeros", resId, resSum, resCout); end
        reset = 0; req = '0;
        settle();
        nChecks++;
        if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL idle_gnt got %b want 0000", gnt); end
        clockEdge();
    endtask

    task automatic test_single();
        doReset();
        req = 4'b0001;
        setOps(0, 32'h7FFFFFFF, 32'h00000001, 1'b0);
        settle();
        nChecks++;
        if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL single_gnt got %b want 0001", gnt); end
        nChecks++;
        if ({addA, addB, addCin} !== {32'h7FFFFFFF, 32'h00000001, 1'b0}) begin
            nFails++; $display("[TB] FAIL single_adder_in got %h %h %b want 7fffffff 00000001 0", addA, addB, addCin);
        end
        clockEdge();
        req = '0;
        nChecks++;
        if ({resValid, resId, resSum, resCout} !== {1'b1, 2'd0, 32'h80000000, 1'b0}) begin
            nFails++; $display("[TB] FAIL single_result got v=%b id=%0d sum=%h cout=%b want v=1 id=0 sum=80000000 cout=0", resValid, resId, resSum, resCout);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] expSum [5] = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h2, 32'hFFFFFFFF};
        bit           expCout [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        doReset();
        for (int k = 0; k < N; k++) setOps(k, W'(k), 32'hFFFFFFFF, 1'b0);
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            settle();
            nChecks++;
            if (gnt !== (4'b0001 << (c % 4))) begin nFails++; $display("[TB] FAIL rr_gnt[%0d] got %b want %b", c, gnt, 4'b0001 << (c % 4)); end
            clockEdge();
            nChecks++;
            if ({resId, resSum, resCout} !== {IW'(c % 4), expSum[c], expCout[c]}) begin
                nFails++; $display("[TB] FAIL rr_result[%0d] got id=%0d sum=%h cout=%b want id=%0d sum=%h cout=%b",
                                   c, resId, resSum, resCout, c % 4, expSum[c], expCout[c]);
            end
        end
    endtask

    // Continues from the round-robin state: slot holds requester 0's result, pointer at 1.
    task automatic test_backpressure();
        req = 4'b0011; resReady = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            nChecks++;
            if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL bp_gnt[%0d] got %b want 0000", c, gnt); end
            clockEdge();
            nChecks++;
            if ({resValid, resId, resSum, resCout} !== {1'b1, 2'd0, 32'hFFFFFFFF, 1'b0}) begin
                nFails++; $display("[TB] FAIL bp_hold[%0d] got v=%b id=%0d sum=%h cout=%b want v=1 id=0 sum=ffffffff cout=0", c, resValid, resId, resSum, resCout);
            end
        end
        resReady = 1;
        settle();
        nChecks++;
        if (gnt !== 4'b0010) begin nFails++; $display("[TB] FAIL bp_resume_gnt got %b want 0010", gnt); end
        clockEdge();
        nChecks++;
        if ({resId, resSum, resCout} !== {2'd1, 32'h0, 1'b1}) begin
            nFails++; $display("[TB] FAIL bp_resume_result got id=%0d sum=%h cout=%b want id=1 sum=0 cout=1", resId, resSum, resCout);
        end
        req = 4'b0001;
        settle();
        nChecks++;
        if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL bp_next_gnt got %b want 0001", gnt); end
        clockEdge();
        req = '0;
    endtask

    task automatic test_multiword();
        doReset();
        req = 4'b0100; lock = 4'b0100;
        setOps(2, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        setOps(0, 32'h12345678, 32'h1, 1'b0);
        settle();
        nChecks++;
        if ({gnt, addCin} !== {4'b0100, 1'b0}) begin nFails++; $display("[TB] FAIL mw_word0_gnt got %b cin=%b want 0100 cin=0", gnt, addCin); end
        clockEdge();
        nChecks++;
        if ({resSum, resCout, locked} !== {32'h0, 1'b1, 1'b1}) begin
            nFails++; $display("[TB] FAIL mw_word0_result got sum=%h cout=%b locked=%b want 0 1 1", resSum, resCout, locked);
        end
        req = 4'b0101; lock = 4'b0000;
        setOps(2, 32'h0, 32'h0, 1'b0);
        settle();
        nChecks++;
        if ({gnt, addCin} !== {4'b0100, 1'b1}) begin nFails++; $display("[TB] FAIL mw_word1_gnt got %b cin=%b want 0100 cin=1", gnt, addCin); end
        clockEdge();
        nChecks++;
        if ({resSum, resCout, locked} !== {32'h1, 1'b0, 1'b0}) begin
            nFails++; $display("[TB] FAIL mw_word1_result got sum=%h cout=%b locked=%b want 1 0 0", resSum, resCout, locked);
        end
        req = 4'b1001;
        settle();
        nChecks++;
        if (gnt !== 4'b1000) begin nFails++; $display("[TB] FAIL mw_after_gnt got %b want 1000", gnt); end
        clockEdge();
        req = 4'b0001;
        settle();
        nChecks++;
        if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL mw_req0_gnt got %b want 0001", gnt); end
        clockEdge();
        req = '0;
    endtask

    task automatic test_abandon();
        doReset();
        req = 4'b0010; lock = 4'b0010;
        setOps(1, 32'hAAAA5555, 32'h5555AAAA, 1'b1);
        settle();
        nChecks++;
        if (gnt !== 4'b0010) begin nFails++; $display("[TB] FAIL ab_first_gnt got %b want 0010", gnt); end
        clockEdge();
        req = 4'b1101; lock = '0;
        settle();
        nChecks++;
        if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL ab_drop_gnt got %b want 0000", gnt); end
        clockEdge();
        nChecks++;
        if ({locked, resValid} !== 2'b00) begin nFails++; $display("[TB] FAIL ab_state got locked=%b valid=%b want 0 0", locked, resValid); end
        settle();
        nChecks++;
        if (gnt !== 4'b0100) begin nFails++; $display("[TB] FAIL ab_resume_gnt got %b want 0100", gnt); end
        clockEdge();
        req = '0;
    endtask

    task automatic test_reset_mid_chain();
        doReset();
        req = 4'b0100; lock = 4'b0100;
        settle();
        clockEdge();
        nChecks++;
        if ({locked, resValid} !== 2'b11) begin nFails++; $display("[TB] FAIL rmc_locked got locked=%b valid=%b want 1 1", locked, resValid); end
        reset = 1; req = 4'b1111; resReady = 0;
        settle();
        nChecks++;
        if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL rmc_reset_gnt got %b want 0000", gnt); end
        clockEdge();
        nChecks++;
        if ({locked, resValid} !== 2'b00) begin nFails++; $display("[TB] FAIL rmc_after_reset got locked=%b valid=%b want 0 0", locked, resValid); end
        reset = 0; lock = '0; resReady = 1;
        settle();
        nChecks++;
        if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL rmc_first_gnt got %b want 0001", gnt); end
        clockEdge();
        req = '0;
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            settle();
            nChecks++;
            if (gnt !== eGnt) begin nFails++; $display("[TB] FAIL rand_gnt[%0d] got %b want %b", c, gnt, eGnt); end
            nChecks++;
            if ({addA, addB, addCin} !== {eA, eB, eCin}) begin
                nFails++; $display("[TB] FAIL rand_adder_in[%0d] got %h %h %b want %h %h %b", c, addA, addB, addCin, eA, eB, eCin);
            end
            nChecks++;
            if (!$onehot0(gnt) || (gnt & ~req) != '0) begin nFails++; $display("[TB] FAIL rand_gnt_legal[%0d] got gnt=%b req=%b want onehot0 subset", c, gnt, req); end
            clockEdge();
            nChecks++;
            if ({resValid, resId, resSum, resCout, locked} !== {mValid, IW'(mId), mSum, mCout, mLocked}) begin
                nFails++; $display("[TB] FAIL rand_result[%0d] got v=%b id=%0d sum=%h cout=%b lk=%b want v=%b id=%0d sum=%h cout=%b lk=%b",
                                   c, resValid, resId, resSum, resCout, locked, mValid, mId, mSum, mCout, mLocked);
            end
            for (int k = 0; k < N; k++) begin
                if (eIdx == k || (!req[k] && $urandom_range(3) == 0)) begin
                    req[k]  = (eIdx == k) ? ($urandom_range(3) != 0) : 1'b1;
                    lock[k] = ($urandom_range(2) == 0);
                    setOps(k, ($urandom_range(3) == 0) ? 32'hFFFFFFFF : W'($urandom), W'($urandom), 1'($urandom));
                end
            end
            resReady = ($urandom_range(9) < 7);
            reset    = ($urandom_range(63) == 0);
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_multiword();
        test_abandon();
        test_reset_mid_chain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one external combinational WIDTH-bit adder (A, B, Cin -> out, Cout) among NREQ requesters.
- Arbitration is round-robin. The block drives the adder inputs from the winning requester and registers the adder outputs into a single result slot.
- A per-requester lock chains consecutive grants into a multi-word add by feeding back the registered carry.
- Sits between the datapath clients (ALU ops, address generation) and the shared adder instance.

Parameters:
- WIDTH, 32, operand/sum width of the shared adder
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID = clog2(NREQ)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; held with operands stable until granted
- lock  input  NREQ  requester holds ownership after this grant (multi-word add)
- a_in  input  NREQ*WIDTH  operand A, requester k at bits [k*WIDTH +: WIDTH]
- b_in  input  NREQ*WIDTH  operand B, same packing
- cin_in  input  NREQ  carry-in for first/unlocked word
- gnt  output  NREQ  one-hot combinational grant, this cycle
- add_a  output  WIDTH  to shared adder A
- add_b  output  WIDTH  to shared adder B
- add_cin  output  1  to shared adder Cin
- add_out  input  WIDTH  from shared adder out
- add_cout  input  1  from shared adder Cout
- res_valid  output  1  result slot occupied
- res_ready  input  1  consumer accepts result this cycle
- res_id  output  IDW  requester that produced result
- res_sum  output  WIDTH  registered sum
- res_cout  output  1  registered carry-out
- locked  output  1  arbiter in LOCKED state

Behaviour:
- Slot free condition: free = !res_valid || res_ready. Issue occurs only when free.
- States:
  - ARB: winner = first k with req[k]=1, searching ptr, ptr+1, ... mod NREQ.
  - LOCKED: only the owner is eligible; all other requests are ignored.
- Grant: when free and a winner exists, gnt[winner]=1 combinationally.
  - add_a/add_b take the winner's operands.
  - add_cin = cin_in[winner] in ARB; add_cin = carry_q in LOCKED.
  - Otherwise gnt=0 and add_a/add_b/add_cin = 0.
- Latency: one cycle. On the clock edge after a grant: res_sum<=add_out, res_cout<=add_cout, res_id<=winner, res_valid<=1, carry_q<=add_cout.
- Slot release: if res_ready && no grant, res_valid<=0 next edge.
- Concurrency: accept and new issue in the same cycle is allowed, giving 1 result/cycle throughput.
- Backpressure: res_valid && !res_ready means no grant. res_* hold stable, the state holds, and ptr/carry_q are unchanged.
- Transitions:
  - ARB -> LOCKED on a grant with lock[winner]=1; owner<=winner.
  - LOCKED stays LOCKED on a grant with lock[owner]=1.
  - LOCKED -> ARB on a grant with lock[owner]=0 (that grant is the final word), or when req[owner]=0 while free. No grant occurs in the abandon cycle.
- ptr update: ptr <= winner+1 mod NREQ on every grant that leaves or stays in ARB. ptr is not advanced while LOCKED. On exit from LOCKED, ptr <= owner+1.
- Arithmetic: the sum is whatever the adder returns, i.e. modulo 2^WIDTH. No sign handling; the block passes data only.
- Reset (synchronous, active-high, applies mid-operation):
  - res_valid=0, res_sum=0, res_cout=0, res_id=0.
  - State ARB, ptr=0, carry_q=0, owner=0.
  - gnt=0 during the reset cycle.
  - Any in-flight locked sequence is abandoned.
- No req asserted: outputs idle, ptr unchanged.
- Assertions (verification): gnt is one-hot-or-zero; gnt[k] implies req[k]; res_* stable while res_valid && !res_ready.

Test Plan:
- Reset, then req=0001, a0=0x7FFFFFFF, b0=0x00000001, cin0=0, res_ready=1 -> gnt=0001 same cycle; next cycle res_valid=1, res_id=0, res_sum=0x80000000, res_cout=0.
- All four req held, res_ready=1, operands k: a=k, b=0xFFFFFFFF -> grants 0,1,2,3,0 on consecutive cycles; res_sum sequence 0xFFFFFFFF, 0x00000000 (cout=1), 0x00000001 (cout=1), 0x00000002 (cout=1), 0xFFFFFFFF (cout=0).
- Backpressure: res_ready=0 with req=0011 pending -> gnt=0 for 3 cycles, res_* frozen; raise res_ready -> grant resumes at the ptr winner, no requester skipped.
- Multi-word: req2 with lock2=1; word0 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0, cout=1. Then lock2=0; word1 a=0, b=0 -> add_cin=1, sum=0x00000001. req0 asserted throughout gets no grant until the chain ends; next grant goes to req3 if set, else req0.
- Abandon: locked owner drops req mid-chain -> locked deasserts next cycle and no grant is issued that cycle; arbitration resumes from owner+1.
- Reset mid-chain with res_valid=1 -> next cycle res_valid=0, locked=0, ptr=0; req=1111 then grants requester 0 first.
